jtkunio_gfx_arb: RTL and testbench

Shares one 32-bit graphics ROM port (SDRAM bank slot) among the three video fetchers: char, scroll and object.
Each requester keeps a one-entry cache of address and data. A round-robin scheduler serialises cache misses onto the ROM port.
The block sits between jtkunio_char/jtkunio_scroll/jtkunio_obj and the SDRAM controller. Each fetcher keeps its usual addr/cs/ok/data contract.

---
 rtl/jtkunio_gfx_arb_pkg.sv | 27 ++
 rtl/jtkunio_gfx_arb_slot.sv | 51 +++++
 rtl/jtkunio_gfx_arb.sv | 111 +++++++++++
 tb/tb_jtkunio_gfx_arb.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/jtkunio_gfx_arb_pkg.sv
// Shared types and helpers for the jtkunio graphics ROM arbiter.
//   state_t  : arbiter FSM states (IDLE waits for a miss, WAIT holds the ROM request)
//   CHAR/SCR/OBJ : requester indices, also the bit positions in pending vectors
//   next_rr  : round-robin pick of the first pending requester after 'last'
package jtkunio_gfx_arb_pkg;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  localparam logic [1:0] CHAR = 2'd0;
  localparam logic [1:0] SCR  = 2'd1;
  localparam logic [1:0] OBJ  = 2'd2;

  // Search order starts just after 'last' and wraps CHAR->SCR->OBJ->CHAR,
  // so 'last' itself is only picked when it is the sole pending requester.
  function automatic logic [1:0] next_rr(input logic [1:0] last,
                                         input logic [2:0] pending);
    logic [1:0] r;
    r = last;
    case (last)
      CHAR:    r = pending[SCR]  ? SCR  : pending[OBJ]  ? OBJ  : CHAR;
      SCR:     r = pending[OBJ]  ? OBJ  : pending[CHAR] ? CHAR : SCR;
      default: r = pending[CHAR] ? CHAR : pending[SCR]  ? SCR  : OBJ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jtkunio_gfx_arb_slot.sv
// One-entry cache for a single graphics fetcher.
//   clk, rst      : clock, synchronous active-high reset
//   i_cs, i_addr  : fetcher request and word address
//   i_load        : grant strobe; captures i_addr as tag and invalidates
//   i_fill        : ROM data return strobe; stores i_fill_data and validates
//   o_ok          : cached data matches the current address
//   o_pending     : request outstanding (cs without a hit)
//   o_data        : registered cache data
module jtkunio_gfx_arb_slot #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_cs,
  input  logic [W-1:0] i_addr,
  input  logic         i_load,
  input  logic         i_fill,
  input  logic [31:0]  i_fill_data,
  output logic         o_ok,
  output logic         o_pending,
  output logic [31:0]  o_data
);

  logic [W-1:0] r_tag;
  logic [31:0]  r_data;
  logic         r_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      // load and fill never coincide for one slot: the arbiter only grants
      // from IDLE and only fills from WAIT
      if (i_load) begin
        r_tag   <= i_addr;
        r_valid <= 1'b0;
      end
      if (i_fill) begin
        r_data  <= i_fill_data;
        r_valid <= 1'b1;
      end
    end
  end

  assign o_ok      = i_cs & r_valid & (r_tag == i_addr);
  assign o_pending = i_cs & ~o_ok;
  assign o_data    = r_data;

endmodule

// File: rtl/jtkunio_gfx_arb.sv
// Graphics ROM arbiter: shares one 32-bit ROM port among char, scroll and
// object fetchers. Each fetcher has a one-entry cache; misses are served
// one at a time in round-robin order.
//   clk, rst                      : clock, synchronous active-high reset
//   char_/scr_/obj_ cs,addr       : fetcher requests
//   char_/scr_/obj_ data,ok       : cached data and hit flag
//   rom_cs, rom_addr              : ROM request, held until rom_ok
//   rom_data, rom_ok              : ROM return, only honoured in WAIT
module jtkunio_gfx_arb
  import jtkunio_gfx_arb_pkg::*;
#(
  parameter int             CW         = 14,
  parameter int             SW         = 17,
  parameter int             OW         = 18,
  parameter int             AW         = 20,
  parameter logic [AW-1:0]  SCR_OFFSET = 20'h04000,
  parameter logic [AW-1:0]  OBJ_OFFSET = 20'h24000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          char_cs,
  input  logic [CW-1:0] char_addr,
  output logic [31:0]   char_data,
  output logic          char_ok,
  input  logic          scr_cs,
  input  logic [SW-1:0] scr_addr,
  output logic [31:0]   scr_data,
  output logic          scr_ok,
  input  logic          obj_cs,
  input  logic [OW-1:0] obj_addr,
  output logic [31:0]   obj_data,
  output logic          obj_ok,
  output logic          rom_cs,
  output logic [AW-1:0] rom_addr,
  input  logic [31:0]   rom_data,
  input  logic          rom_ok
);

  state_t        r_state, w_state_nx;
  logic [1:0]    r_owner, r_last;
  logic [1:0]    w_pick;
  logic [2:0]    w_pend, w_load, w_fill;
  logic          w_grant, w_done;
  logic [AW-1:0] w_req_addr;

  jtkunio_gfx_arb_slot #(.W(CW)) u_char (
    .clk(clk), .rst(rst), .i_cs(char_cs), .i_addr(char_addr),
    .i_load(w_load[CHAR]), .i_fill(w_fill[CHAR]), .i_fill_data(rom_data),
    .o_ok(char_ok), .o_pending(w_pend[CHAR]), .o_data(char_data)
  );

  jtkunio_gfx_arb_slot #(.W(SW)) u_scr (
    .clk(clk), .rst(rst), .i_cs(scr_cs), .i_addr(scr_addr),
    .i_load(w_load[SCR]), .i_fill(w_fill[SCR]), .i_fill_data(rom_data),
    .o_ok(scr_ok), .o_pending(w_pend[SCR]), .o_data(scr_data)
  );

  jtkunio_gfx_arb_slot #(.W(OW)) u_obj (
    .clk(clk), .rst(rst), .i_cs(obj_cs), .i_addr(obj_addr),
    .i_load(w_load[OBJ]), .i_fill(w_fill[OBJ]), .i_fill_data(rom_data),
    .o_ok(obj_ok), .o_pending(w_pend[OBJ]), .o_data(obj_data)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nx;
  end

  // next state
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (|w_pend) w_state_nx = WAIT;
      WAIT:    if (rom_ok)  w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // outputs of the FSM: grant/fill strobes and the granted ROM address
  always_comb begin
    w_grant = (r_state == IDLE) & (|w_pend);
    w_done  = (r_state == WAIT) & rom_ok;
    w_pick  = next_rr(r_last, w_pend);
    w_load  = w_grant ? (3'b001 << w_pick)  : 3'b000;
    w_fill  = w_done  ? (3'b001 << r_owner) : 3'b000;
    case (w_pick)
      SCR:     w_req_addr = AW'(scr_addr) + SCR_OFFSET;
      OBJ:     w_req_addr = AW'(obj_addr) + OBJ_OFFSET;
      default: w_req_addr = AW'(char_addr);
    endcase
  end

  // ROM port and arbitration history; rom_addr is left as-is after a fill
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_cs   <= 1'b0;
      rom_addr <= '0;
      r_owner  <= CHAR;
      r_last   <= OBJ;
    end else if (w_grant) begin
      rom_cs   <= 1'b1;
      rom_addr <= w_req_addr;
      r_owner  <= w_pick;
      r_last   <= w_pick;
    end else if (w_done) begin
      rom_cs   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtkunio_gfx_arb.sv
module tb_jtkunio_gfx_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        char_cs, scr_cs, obj_cs;
  logic [13:0] char_addr;
  logic [16:0] scr_addr;
  logic [17:0] obj_addr;
  logic [31:0] char_data, scr_data, obj_data;
  logic        char_ok, scr_ok, obj_ok;
  logic        rom_cs;
  logic [19:0] rom_addr;
  logic [31:0] rom_data;
  logic        rom_ok;

  always #5 clk = ~clk;

  jtkunio_gfx_arb dut (
    .clk(clk), .rst(rst),
    .char_cs(char_cs), .char_addr(char_addr), .char_data(char_data), .char_ok(char_ok),
    .scr_cs(scr_cs),   .scr_addr(scr_addr),   .scr_data(scr_data),   .scr_ok(scr_ok),
    .obj_cs(obj_cs),   .obj_addr(obj_addr),   .obj_data(obj_data),   .obj_ok(obj_ok),
    .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data), .rom_ok(rom_ok)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [19:0] OFF [3] = '{20'h00000, 20'h04000, 20'h24000};
  logic [19:0] m_tag [3];
  logic [31:0] m_dat [3];
  bit          m_val [3];
  bit          m_busy;
  int          m_own, m_last;
  logic [19:0] m_radr;

  function automatic bit cs_of(int i);
    return (i == 0) ? char_cs : (i == 1) ? scr_cs : obj_cs;
  endfunction

  function automatic logic [19:0] addr_of(int i);
    return (i == 0) ? 20'(char_addr) : (i == 1) ? 20'(scr_addr) : 20'(obj_addr);
  endfunction

  function automatic bit m_ok(int i);
    return cs_of(i) && m_val[i] && (m_tag[i] == addr_of(i));
  endfunction

  task automatic model_step();
    bit found;
    if (rst) begin
      for (int i = 0; i < 3; i++) begin m_val[i] = 0; m_dat[i] = 0; m_tag[i] = 0; end
      m_busy = 0; m_last = 2; m_own = 0; m_radr = 0;
    end else if (!m_busy) begin
      found = 0;
      for (int k = 1; k <= 3; k++) begin
        int idx;
        idx = (m_last + k) % 3;
        if (!found && cs_of(idx) && !m_ok(idx)) begin
          found = 1;
          m_own = idx; m_last = idx; m_busy = 1;
          m_tag[idx] = addr_of(idx); m_val[idx] = 0;
          m_radr = addr_of(idx) + OFF[idx];
        end
      end
    end else if (rom_ok) begin
      m_dat[m_own] = rom_data; m_val[m_own] = 1; m_busy = 0;
    end
  endtask

  // one clock: advance the model with the inputs the DUT sees, then compare
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("rom_cs",    {31'd0, rom_cs}, {31'd0, m_busy});
    chk("rom_addr",  {12'd0, rom_addr}, {12'd0, m_radr});
    chk("char_ok",   {31'd0, char_ok}, {31'd0, m_ok(0)});
    chk("scr_ok",    {31'd0, scr_ok},  {31'd0, m_ok(1)});
    chk("obj_ok",    {31'd0, obj_ok},  {31'd0, m_ok(2)});
    chk("char_data", char_data, m_dat[0]);
    chk("scr_data",  scr_data,  m_dat[1]);
    chk("obj_data",  obj_data,  m_dat[2]);
  endtask

  task automatic wait_cs(input string tag);
    for (int t = 0; t < 10 && !rom_cs; t++) cyc();
    chk(tag, {31'd0, rom_cs}, 32'd1);
  endtask

  function automatic int who(input logic [19:0] a);
    return (a >= 20'h24000) ? 2 : (a >= 20'h04000) ? 1 : 0;
  endfunction

  int exp_ord [4] = '{0, 1, 2, 0};
  int lat;

  initial begin
    rst = 1; rom_ok = 0; rom_data = 0;
    char_cs = 0; scr_cs = 0; obj_cs = 0;
    char_addr = 0; scr_addr = 0; obj_addr = 0;
    m_busy = 0; m_last = 2; m_own = 0; m_radr = 0;
    for (int i = 0; i < 3; i++) begin m_val[i] = 0; m_dat[i] = 0; m_tag[i] = 0; end

    // reset state
    cyc();
    rst = 0;
    chk("rst_rom_cs", {31'd0, rom_cs}, 32'd0);
    chk("rst_rom_addr", {12'd0, rom_addr}, 32'd0);
    chk("rst_char_data", char_data, 32'd0);

    // first char miss and fill
    char_cs = 1; char_addr = 14'h0123;
    cyc();
    chk("t1_cs", {31'd0, rom_cs}, 32'd1);
    chk("t1_addr", {12'd0, rom_addr}, 32'h00123);
    cyc();
    rom_ok = 1; rom_data = 32'hDEADBEEF;
    cyc();
    rom_ok = 0;
    chk("t1_ok", {31'd0, char_ok}, 32'd1);
    chk("t1_data", char_data, 32'hDEADBEEF);
    chk("t1_cs_lo", {31'd0, rom_cs}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t2_hit", {31'd0, char_ok}, 32'd1);
      chk("t2_nocs", {31'd0, rom_cs}, 32'd0);
    end

    // simultaneous scroll and object misses after a char grant
    char_cs = 0; scr_cs = 1; scr_addr = 17'h00010; obj_cs = 1; obj_addr = 18'h00020;
    cyc();
    chk("t3_scr_addr", {12'd0, rom_addr}, 32'h04010);
    rom_ok = 1; rom_data = 32'h5C5C0010;
    cyc();
    rom_ok = 0;
    cyc();
    chk("t3_obj_addr", {12'd0, rom_addr}, 32'h24020);
    rom_ok = 1; rom_data = 32'h0B0B0020;
    cyc();
    rom_ok = 0;

    // all three miss continuously
    char_cs = 1; char_addr = 14'h0100; scr_addr = 17'h00100; obj_addr = 18'h00100;
    for (int g = 0; g < 4; g++) begin
      wait_cs("t4_tmo");
      chk("t4_order", who(rom_addr), exp_ord[g]);
      cyc(); cyc();
      rom_ok = 1; rom_data = $urandom;
      cyc();
      rom_ok = 0;
      chk("t4_gap", {31'd0, rom_cs}, 32'd0);
      char_addr++; scr_addr++; obj_addr++;
    end

    // char address changes while its fetch is in flight
    scr_cs = 0; obj_cs = 0; char_addr = 14'h0001;
    wait_cs("t5_tmo");
    chk("t5_addr1", {12'd0, rom_addr}, 32'h00001);
    char_addr = 14'h0002;
    cyc();
    rom_ok = 1; rom_data = 32'h11111111;
    cyc();
    rom_ok = 0;
    chk("t5_stale", {31'd0, char_ok}, 32'd0);
    cyc();
    chk("t5_recs", {31'd0, rom_cs}, 32'd1);
    chk("t5_addr2", {12'd0, rom_addr}, 32'h00002);
    rom_ok = 1; rom_data = 32'h22222222;
    cyc();
    rom_ok = 0;
    chk("t5_ok", {31'd0, char_ok}, 32'd1);

    // reset in the middle of a fetch
    char_addr = 14'h0003;
    wait_cs("t6_tmo");
    rst = 1;
    cyc();
    rst = 0;
    chk("t6_cs", {31'd0, rom_cs}, 32'd0);
    chk("t6_ok", {31'd0, char_ok}, 32'd0);
    char_cs = 0;
    rom_ok = 1;
    cyc();
    rom_ok = 0;
    cyc();
    chk("t6_idle", {31'd0, rom_cs}, 32'd0);

    // randomized traffic against the model
    lat = 0;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) char_cs = ~char_cs;
      if ($urandom_range(0, 7) == 0) scr_cs  = ~scr_cs;
      if ($urandom_range(0, 7) == 0) obj_cs  = ~obj_cs;
      if ($urandom_range(0, 5) == 0) char_addr = 14'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) scr_addr  = 17'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) obj_addr  = ($urandom_range(0, 9) == 0) ? 18'($urandom) : 18'($urandom_range(0, 3));
      rom_data = $urandom;
      if (m_busy) begin
        if (lat == 0) lat = $urandom_range(1, 4);
        lat--;
        rom_ok = (lat == 0);
      end else begin
        rom_ok = ($urandom_range(0, 9) == 0);
      end
      cyc();
    end
    rst = 0; rom_ok = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
